// File: rtl/triangle_voice_sequencer.sv
// triangle_voice_sequencer
//   Shares one triangle tone generator between NUM_VOICES voices. Each voice
//   owns a phase accumulator plus frequency, gate and ringmod settings. A
//   sample_tick starts a frame. The frame steps every voice once, in order
//   0..N-1, and returns one registered sample per voice.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   sample_tick         one-cycle pulse that starts a frame
//   cfg_we, cfg_voice,  config write: frequency, gate and ringmod for one voice.
//   cfg_freq, cfg_gate, Writes to voice indices >= NUM_VOICES are ignored.
//   cfg_ringmod
//   tg_accumulator,     phase, ringmod enable and modulator MSB presented to
//   tg_en_ringmod,      the shared generator
//   tg_ringmod_source
//   tg_dout             combinational sample returned by the shared generator
//   sample_out,         captured sample and the voice it belongs to
//   sample_voice
//   sample_valid        one-cycle pulse per voice
//   frame_done          one-cycle pulse on the last voice's sample_valid
//   busy                high while a frame is in progress
//   overrun             sticky; set when a tick arrives during a frame
module triangle_voice_sequencer #(
  parameter int NUM_VOICES       = 3,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int OUTPUT_BITS      = 12,
  parameter int FREQ_BITS        = 16,
  localparam int VIDX_BITS       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_tick,
  input  logic                        cfg_we,
  input  logic [VIDX_BITS-1:0]        cfg_voice,
  input  logic [FREQ_BITS-1:0]        cfg_freq,
  input  logic                        cfg_gate,
  input  logic                        cfg_ringmod,
  output logic [ACCUMULATOR_BITS-1:0] tg_accumulator,
  output logic                        tg_en_ringmod,
  output logic                        tg_ringmod_source,
  input  logic [OUTPUT_BITS-1:0]      tg_dout,
  output logic [OUTPUT_BITS-1:0]      sample_out,
  output logic [VIDX_BITS-1:0]        sample_voice,
  output logic                        sample_valid,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_EMIT} state_t;

  localparam logic [VIDX_BITS-1:0] LAST_VOICE = VIDX_BITS'(NUM_VOICES - 1);

  state_t                      state;
  logic [VIDX_BITS-1:0]        voice;
  logic [ACCUMULATOR_BITS-1:0] acc     [NUM_VOICES];
  logic [FREQ_BITS-1:0]        freq    [NUM_VOICES];
  logic                        gate    [NUM_VOICES];
  logic                        ringmod [NUM_VOICES];

  logic [VIDX_BITS-1:0]        prev_voice;
  logic [ACCUMULATOR_BITS-1:0] next_acc;
  logic                        cfg_hit;

  // The modulator is the previous voice, wrapping from voice 0 to voice N-1.
  // The next phase is computed from the stored settings. A config write in
  // the same cycle therefore only takes effect in the following frame.
  always_comb begin
    prev_voice = (voice == '0) ? LAST_VOICE : voice - VIDX_BITS'(1);
    next_acc   = gate[voice] ? acc[voice] + ACCUMULATOR_BITS'(freq[voice]) : '0;
    cfg_hit    = cfg_we && (int'(cfg_voice) < NUM_VOICES);
  end

  // Frame sequencer. Each voice takes one ADD cycle, which updates the phase
  // and drives the generator, and one EMIT cycle, which captures the
  // generator's combinational result. The modulator MSB is read from the
  // stored accumulator. Voice v>0 therefore sees voice v-1 already updated
  // in this frame, while voice 0 sees voice N-1 from the previous frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      voice             <= '0;
      tg_accumulator    <= '0;
      tg_en_ringmod     <= 1'b0;
      tg_ringmod_source <= 1'b0;
      sample_out        <= '0;
      sample_voice      <= '0;
      sample_valid      <= 1'b0;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc[i]     <= '0;
        freq[i]    <= '0;
        gate[i]    <= 1'b0;
        ringmod[i] <= 1'b0;
      end
    end else begin
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;

      if (cfg_hit) begin
        freq[cfg_voice]    <= cfg_freq;
        gate[cfg_voice]    <= cfg_gate;
        ringmod[cfg_voice] <= cfg_ringmod;
      end

      if (sample_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            state <= S_ADD;
            voice <= '0;
            busy  <= 1'b1;
          end
        end
        S_ADD: begin
          acc[voice]        <= next_acc;
          tg_accumulator    <= next_acc;
          tg_en_ringmod     <= ringmod[voice];
          tg_ringmod_source <= acc[prev_voice][ACCUMULATOR_BITS-1];
          state             <= S_EMIT;
        end
        S_EMIT: begin
          sample_out   <= tg_dout;
          sample_voice <= voice;
          sample_valid <= 1'b1;
          frame_done   <= (voice == LAST_VOICE);
          if (voice == LAST_VOICE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            voice <= voice + VIDX_BITS'(1);
            state <= S_ADD;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_voice_sequencer.sv
// tb_triangle_voice_sequencer
//   Drives triangle_voice_sequencer with directed scenarios and a randomized
//   run. A behavioural reference tracks the expected outputs from the frame
//   timing rules. The shared triangle generator is modelled as a
//   combinational function.
module tb_triangle_voice_sequencer;

  localparam int NV  = 3;
  localparam int ACC = 24;
  localparam int OB  = 12;
  localparam int FB  = 16;
  localparam int VB  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_tick;
  logic          cfg_we;
  logic [VB-1:0] cfg_voice;
  logic [FB-1:0] cfg_freq;
  logic          cfg_gate;
  logic          cfg_ringmod;
  logic [ACC-1:0] tg_accumulator;
  logic          tg_en_ringmod;
  logic          tg_ringmod_source;
  logic [OB-1:0] tg_dout;
  logic [OB-1:0] sample_out;
  logic [VB-1:0] sample_voice;
  logic          sample_valid;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  // Shared triangle generator: the top phase bits, folded by the effective
  // MSB. Ringmod XORs the modulator MSB into the effective MSB.
  function automatic logic [OB-1:0] tri_wave(input logic [ACC-1:0] a, input logic en,
                                             input logic src);
    logic msb;
    msb = a[ACC-1] ^ (en & src);
    return a[ACC-2 -: OB] ^ {OB{msb}};
  endfunction

  assign tg_dout = tri_wave(tg_accumulator, tg_en_ringmod, tg_ringmod_source);

  triangle_voice_sequencer #(
    .NUM_VOICES(NV), .ACCUMULATOR_BITS(ACC), .OUTPUT_BITS(OB), .FREQ_BITS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_freq(cfg_freq), .cfg_gate(cfg_gate),
    .cfg_ringmod(cfg_ringmod), .tg_accumulator(tg_accumulator),
    .tg_en_ringmod(tg_en_ringmod), .tg_ringmod_source(tg_ringmod_source),
    .tg_dout(tg_dout), .sample_out(sample_out), .sample_voice(sample_voice),
    .sample_valid(sample_valid), .frame_done(frame_done), .busy(busy),
    .overrun(overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state.
  logic [ACC-1:0] m_acc  [NV];
  logic [FB-1:0]  m_freq [NV];
  logic           m_gate [NV];
  logic           m_ring [NV];
  logic [OB-1:0]  m_pending;
  logic [ACC-1:0] e_tg_acc;
  logic           e_en, e_src, e_valid, e_done, e_busy, e_over;
  logic [OB-1:0]  e_sample;
  logic [VB-1:0]  e_voice;
  int edge_n = 0;
  int m_n0   = -1000;

  // The model works from the frame timeline. If a tick is accepted at edge n0,
  // the edge n0+2v+1 computes voice v's phase, and the edge n0+2v+2 publishes
  // voice v's sample. The frame occupies edges n0+1..n0+2N. A tick on any of
  // those edges is dropped and counted as an overrun.
  always @(posedge clk) begin
    int k;
    int v;
    edge_n++;
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin
        m_acc[i] = '0; m_freq[i] = '0; m_gate[i] = 1'b0; m_ring[i] = 1'b0;
      end
      m_pending = '0; e_tg_acc = '0; e_en = 1'b0; e_src = 1'b0;
      e_sample = '0; e_voice = '0; e_valid = 1'b0; e_done = 1'b0;
      e_busy = 1'b0; e_over = 1'b0;
      m_n0 = -1000;
    end else begin
      k = edge_n - m_n0;
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (k >= 1 && k <= 2 * NV) begin
        if (k % 2 == 1) begin
          v = (k - 1) / 2;
          e_src = m_acc[(v + NV - 1) % NV][ACC-1];
          m_acc[v] = m_gate[v] ? m_acc[v] + {8'h00, m_freq[v]} : '0;
          e_tg_acc = m_acc[v];
          e_en = m_ring[v];
          m_pending = tri_wave(e_tg_acc, e_en, e_src);
        end else begin
          v = k / 2 - 1;
          e_sample = m_pending;
          e_voice = VB'(v);
          e_valid = 1'b1;
          e_done = (v == NV - 1);
        end
        if (sample_tick) e_over = 1'b1;
      end else if (sample_tick) begin
        m_n0 = edge_n;
      end
      if (cfg_we && cfg_voice < NV) begin
        m_freq[cfg_voice] = cfg_freq;
        m_gate[cfg_voice] = cfg_gate;
        m_ring[cfg_voice] = cfg_ringmod;
      end
      e_busy = ((edge_n - m_n0) >= 0) && ((edge_n - m_n0) < 2 * NV);
    end
  end

  // Every cycle, compare all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("tg_accumulator", 32'(tg_accumulator), 32'(e_tg_acc));
      checkOutput("tg_en_ringmod", 32'(tg_en_ringmod), 32'(e_en));
      checkOutput("tg_ringmod_source", 32'(tg_ringmod_source), 32'(e_src));
      checkOutput("sample_out", 32'(sample_out), 32'(e_sample));
      checkOutput("sample_voice", 32'(sample_voice), 32'(e_voice));
      checkOutput("sample_valid", 32'(sample_valid), 32'(e_valid));
      checkOutput("frame_done", 32'(frame_done), 32'(e_done));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("overrun", 32'(overrun), 32'(e_over));
    end
  end

  // Per-frame capture filled by run_frame.
  logic [ACC-1:0] fr_acc    [NV];
  logic           fr_src    [NV];
  logic           fr_en     [NV];
  logic [OB-1:0]  fr_sample [NV];
  logic [VB-1:0]  fr_voice  [NV];
  logic           fr_valid  [NV];
  logic           fr_done   [NV];

  // Drive one cycle of inputs at the falling edge. Return one cycle later
  // with the strobes cleared and reset released.
  task automatic applyStimulus(input logic rst, input logic tick, input logic we,
                               input logic [VB-1:0] voice, input logic [FB-1:0] freq,
                               input logic gate, input logic ring);
    rst_n = rst; sample_tick = tick; cfg_we = we; cfg_voice = voice;
    cfg_freq = freq; cfg_gate = gate; cfg_ringmod = ring;
    @(negedge clk);
    rst_n = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input logic [VB-1:0] voice, input logic [FB-1:0] freq,
                           input logic gate, input logic ring);
    applyStimulus(1'b1, 1'b0, 1'b1, voice, freq, gate, ring);
  endtask

  // Tick in cycle T. Record the generator drive at T+2+2v and the sample at
  // T+3+2v. Return in cycle T+7, when the sequencer is idle again.
  task automatic run_frame();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      fr_acc[v] = tg_accumulator; fr_src[v] = tg_ringmod_source; fr_en[v] = tg_en_ringmod;
      @(negedge clk);
      fr_sample[v] = sample_out; fr_voice[v] = sample_voice;
      fr_valid[v] = sample_valid; fr_done[v] = frame_done;
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
    cfg_freq = '0; cfg_gate = 1'b0; cfg_ringmod = 1'b0;
    @(negedge clk);
    do_reset();
    compare_on = 1'b1;
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset sample_valid", 32'(sample_valid), 32'h0);
    checkOutput("reset tg_accumulator", 32'(tg_accumulator), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'h0);

    // Single voice stepping by 0x1000.
    cfg_write(2'd0, 16'h1000, 1'b1, 1'b0);
    run_frame();
    checkOutput("t1 tg_acc v0", 32'(fr_acc[0]), 32'h001000);
    checkOutput("t1 valid v0", 32'(fr_valid[0]), 32'h1);
    checkOutput("t1 voice v0", 32'(fr_voice[0]), 32'h0);
    checkOutput("t1 sample v0", 32'(fr_sample[0]), 32'h002);
    checkOutput("t1 frame_done v0", 32'(fr_done[0]), 32'h0);
    checkOutput("t1 frame_done v2", 32'(fr_done[2]), 32'h1);
    checkOutput("t1 voice v2", 32'(fr_voice[2]), 32'h2);

    // Half-scale step: the MSB sets after 256 frames and wraps after 512.
    do_reset();
    cfg_write(2'd0, 16'h8000, 1'b1, 1'b0);
    for (int f = 1; f <= 512; f++) begin
      run_frame();
      if (f == 256) begin
        checkOutput("t2 acc0 frame256", 32'(fr_acc[0]), 32'h800000);
        checkOutput("t2 sample0 frame256", 32'(fr_sample[0]), 32'hFFF);
      end
      if (f == 512) begin
        checkOutput("t2 acc0 frame512", 32'(fr_acc[0]), 32'h000000);
        checkOutput("t2 sample0 frame512", 32'(fr_sample[0]), 32'h000);
      end
    end

    // Ringmod on voice 1, modulated by voice 0 crossing half scale.
    do_reset();
    cfg_write(2'd0, 16'h8000, 1'b1, 1'b0);
    cfg_write(2'd1, 16'h0100, 1'b1, 1'b1);
    repeat (255) run_frame();
    checkOutput("t3 src1 before", 32'(fr_src[1]), 32'h0);
    checkOutput("t3 sample1 before", 32'(fr_sample[1]), 32'h01F);
    run_frame();
    checkOutput("t3 acc0 cross", 32'(fr_acc[0]), 32'h800000);
    checkOutput("t3 en1", 32'(fr_en[1]), 32'h1);
    checkOutput("t3 src1", 32'(fr_src[1]), 32'h1);
    checkOutput("t3 acc1", 32'(fr_acc[1]), 32'h010000);
    checkOutput("t3 sample1 inverted", 32'(fr_sample[1]), 32'hFDF);

    // A tick during a frame is dropped. A tick once idle starts a new frame.
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t4 overrun before", 32'(overrun), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("t4 overrun after", 32'(overrun), 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("t4 frame_done", 32'(frame_done), 32'h1);
    checkOutput("t4 busy end", 32'(busy), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("t4 busy restart", 32'(busy), 32'h1);
    checkOutput("t4 no extra sample", 32'(sample_valid), 32'h0);
    repeat (6) @(negedge clk);

    // Reset in the middle of a frame.
    do_reset();
    cfg_write(2'd0, 16'h1234, 1'b1, 1'b0);
    run_frame();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    do_reset();
    checkOutput("t5 busy", 32'(busy), 32'h0);
    checkOutput("t5 sample_out", 32'(sample_out), 32'h0);
    checkOutput("t5 tg_accumulator", 32'(tg_accumulator), 32'h0);
    checkOutput("t5 sample_valid", 32'(sample_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t5 quiet valid", 32'(sample_valid), 32'h0);
    end
    cfg_write(2'd0, 16'h0010, 1'b1, 1'b0);
    run_frame();
    checkOutput("t5 acc0 cleared", 32'(fr_acc[0]), 32'h000010);

    // An out-of-range write is ignored. A write during a voice's ADD cycle is
    // applied from the next frame.
    do_reset();
    cfg_write(2'd3, 16'hFFFF, 1'b1, 1'b1);
    run_frame();
    for (int v = 0; v < NV; v++) begin
      checkOutput("t6 ignored acc", 32'(fr_acc[v]), 32'h0);
      checkOutput("t6 ignored en", 32'(fr_en[v]), 32'h0);
    end
    cfg_write(2'd1, 16'h0100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 16'h0200, 1'b1, 1'b0);
    checkOutput("t6 old freq used", 32'(tg_accumulator), 32'h000100);
    repeat (3) @(negedge clk);
    run_frame();
    checkOutput("t6 new freq used", 32'(fr_acc[1]), 32'h000300);

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), VB'($urandom_range(0, 3)),
                    FB'($urandom), ($urandom_range(0, 4) != 0),
                    1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
